debug_tx_scheduler: RTL and testbench

- Shares the debugger UART transmit FIFO between several MIPS debug sources: PC dump, register dump, memory dump and command acknowledge.
- Each requester presents a 32-bit word plus a byte count. The scheduler grants one requester at a time, round-robin.
- It then serializes the granted word MSB-byte-first into the UART write port (wr/w_data), respecting wr_full.
- It sits between the debug state machine/datapath taps and the uart instance, and replaces direct wr/w_data driving.

---
 rtl/debug_tx_scheduler.sv | 98 +++++++++
 tb/tb_debug_tx_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/debug_tx_scheduler.sv
// Round-robin arbiter that shares the debugger UART tx FIFO between debug sources,
// sending each granted word MSB-byte-first through the wr/w_data port.
//
// state | meaning
// IDLE  | waiting for a request; arbitrates on every edge
// SEND  | shifting the captured word out, one byte per non-full cycle
module debug_tx_scheduler #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic [NREQ*2-1:0]      req_size,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        done,
  output logic                   busy,
  input  logic                   wr_full,
  output logic                   wr,
  output logic [7:0]             w_data
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] sr;
  logic [1:0]        cnt;
  logic [IW-1:0]     last;
  logic [IW-1:0]     sel;
  logic              sel_vld;
  logic [DATA_W-1:0] sel_word;
  logic [1:0]        sel_size;
  int                idx;

  // Search downward in distance so the nearest set index after 'last' wins.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    idx     = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (req[idx]) begin
        sel     = IW'(idx);
        sel_vld = 1'b1;
      end
    end
  end

  assign sel_word = req_data[int'(sel)*DATA_W +: DATA_W];
  assign sel_size = req_size[int'(sel)*2 +: 2];

  assign busy   = (state == SEND);
  assign wr     = busy & ~wr_full;
  assign w_data = busy ? sr[DATA_W-1 -: 8] : 8'h00;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_vld) state_nxt = SEND;
      SEND:    if (wr && cnt == 2'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr    <= '0;
      cnt   <= 2'd0;
      last  <= IW'(NREQ - 1);
      grant <= '0;
      done  <= '0;
    end else begin
      grant <= '0;
      done  <= '0;
      if (state == IDLE && sel_vld) begin
        // Left-justify so the most significant valid byte leaves first.
        sr    <= sel_word << (8 * (3 - int'(sel_size)));
        cnt   <= sel_size;
        last  <= sel;
        grant <= ONE_HOT0 << sel;
      end else if (wr) begin
        sr  <= sr << 8;
        cnt <= cnt - 2'd1;
        if (cnt == 2'd0) done <= ONE_HOT0 << last;
      end
    end
  end

endmodule

// File: tb/tb_debug_tx_scheduler.sv
// Scoreboard bench for debug_tx_scheduler: a transaction-level reference model
// predicts grants, byte streams and done pulses; a negedge monitor checks them.
module tb_debug_tx_scheduler;
  localparam int NREQ = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [NREQ*32-1:0]  req_data;
  logic [NREQ*2-1:0]   req_size;
  logic [NREQ-1:0]     grant, done;
  logic                busy, wr_full, wr;
  logic [7:0]          w_data;

  always #5 clk = ~clk;

  debug_tx_scheduler #(.NREQ(NREQ), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_size(req_size),
    .grant(grant), .done(done), .busy(busy), .wr_full(wr_full), .wr(wr), .w_data(w_data)
  );

  typedef struct {int c; int idx;} ev_t;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  ev_t        q_grant[$];
  ev_t        q_done[$];
  logic [7:0] q_byte[$];
  bit         m_busy = 1'b0;
  int         m_rem = 0;
  int         m_last = NREQ - 1;
  int         m_sel;
  int         m_size;
  bit         rearm = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: one transaction at a time, round-robin from the last winner.
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_busy = 1'b0;
      m_rem  = 0;
      m_last = NREQ - 1;
      q_byte.delete();
      q_grant.delete();
      q_done.delete();
    end else if (!m_busy) begin
      if (req != '0) begin
        m_sel = -1;
        for (int k = 1; k <= NREQ; k++)
          if (m_sel < 0 && req[(m_last + k) % NREQ]) m_sel = (m_last + k) % NREQ;
        m_size = int'(req_size[2*m_sel +: 2]);
        q_grant.push_back('{c: cyc, idx: m_sel});
        for (int b = m_size; b >= 0; b--) q_byte.push_back(req_data[32*m_sel + 8*b +: 8]);
        m_rem  = m_size + 1;
        m_busy = 1'b1;
        m_last = m_sel;
      end
    end else if (!wr_full) begin
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 1'b0;
        q_done.push_back('{c: cyc, idx: m_last});
      end
    end
  end

  always @(negedge clk) begin
    ev_t e;
    if (cyc >= 1) begin
      chk("busy", busy, m_busy);
      chk("wr", wr, m_busy && !wr_full);
      if (!m_busy) chk("w_data_idle", w_data, 8'h00);
      if (wr) begin
        if (q_byte.size() == 0) begin
          total++; bad++;
          $display("FAIL byte_extra cyc=%0d actual=%0h required=none", cyc, w_data);
        end else chk("byte", w_data, q_byte.pop_front());
      end
      if (grant != '0 || (q_grant.size() > 0 && q_grant[0].c <= cyc)) begin
        if (q_grant.size() == 0) begin
          total++; bad++;
          $display("FAIL grant_extra cyc=%0d actual=%0h required=0", cyc, grant);
        end else begin
          e = q_grant.pop_front();
          chk("grant_cyc", cyc, e.c);
          chk("grant", grant, 32'(1) << e.idx);
        end
      end
      if (done != '0 || (q_done.size() > 0 && q_done[0].c <= cyc)) begin
        if (q_done.size() == 0) begin
          total++; bad++;
          $display("FAIL done_extra cyc=%0d actual=%0h required=0", cyc, done);
        end else begin
          e = q_done.pop_front();
          chk("done_cyc", cyc, e.c);
          chk("done", done, 32'(1) << e.idx);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) req[i] = 1'b0;
      if (rearm && done[i]) req[i] = 1'b1;
    end
  endtask

  task automatic raise(input int i, input logic [31:0] data, input logic [1:0] size);
    req_data[32*i +: 32] = data;
    req_size[2*i +: 2]   = size;
    req[i]               = 1'b1;
  endtask

  task automatic wait_quiet(input int max);
    int n = 0;
    while ((req != '0 || m_busy) && n < max) begin
      tick();
      n++;
    end
    if (n >= max) begin
      total++; bad++;
      $display("FAIL timeout cyc=%0d actual=busy required=idle within %0d cycles", cyc, max);
    end
    tick();
  endtask

  initial begin
    reset    = 1'b1;
    req      = '0;
    req_data = '0;
    req_size = '0;
    wr_full  = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    repeat (100) tick();

    raise(0, 32'hDEADBEEF, 2'd3);
    wait_quiet(30);

    raise(2, 32'h11223344, 2'd1);
    wait_quiet(30);

    raise(0, 32'hA1B2C3D4, 2'd3);
    repeat (3) tick();
    wr_full = 1'b1;
    repeat (3) tick();
    wr_full = 1'b0;
    wait_quiet(30);

    rearm = 1'b1;
    for (int i = 0; i < NREQ; i++) raise(i, 32'(i), 2'd0);
    repeat (24) tick();
    rearm = 1'b0;
    wait_quiet(40);

    raise(0, 32'hDEADBEEF, 2'd3);
    repeat (3) tick();
    reset = 1'b1;
    raise(1, 32'h55667788, 2'd2);
    raise(3, 32'h99AABBCC, 2'd0);
    tick();
    reset = 1'b0;
    wait_quiet(40);

    repeat (600) begin
      wr_full = ($urandom_range(0, 3) == 0);
      reset   = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && $urandom_range(0, 3) == 0) raise(i, $urandom, 2'($urandom_range(0, 3)));
      tick();
    end
    reset   = 1'b0;
    wr_full = 1'b0;
    wait_quiet(200);

    chk("q_byte_empty", q_byte.size(), 0);
    chk("q_grant_empty", q_grant.size(), 0);
    chk("q_done_empty", q_done.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
